// File: rtl/ps2_rx_buffered.sv
// ps2_rx_buffered
//   PS/2 device-to-host receiver with a show-ahead receive FIFO.
//   The raw PS/2 lines are synchronised and glitch-filtered, 11-bit frames are
//   deserialised (start, 8 data LSB-first, odd parity, stop), and every
//   completed frame is queued as {err, data}. A frame whose falling clock
//   edges stop arriving for TIMEOUT_CYC cycles is abandoned.
//
//   Handshake: rx_valid/rx_data/rx_err always show the FIFO head. A cycle with
//   rd_en=1 and rx_valid=1 consumes the head; rd_en while empty is ignored.
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   ps2d, ps2c      PS/2 data and clock lines (asynchronous)
//   rx_en           allows a new frame to start; a started frame always completes
//   rd_en           pop the head entry
//   clr_ovf         clear the sticky overflow flag
//   rx_data, rx_err head entry byte and its parity/stop error flag
//   rx_valid        FIFO non-empty
//   fifo_count      number of entries held
//   overflow        sticky: a completed frame was dropped because the FIFO was full
//   timeout_tick    one-cycle pulse when a frame is abandoned by timeout
//   busy            receiver is inside a frame (not idle)
module ps2_rx_buffered #(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2d,
    input  logic                          ps2c,
    input  logic                          rx_en,
    input  logic                          rd_en,
    input  logic                          clr_ovf,
    output logic [7:0]                    rx_data,
    output logic                          rx_err,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          timeout_tick,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic                  ps2d_meta_q, ps2d_meta_d;
    logic                  ps2d_sync_q, ps2d_sync_d;
    logic [FILTER_LEN-1:0] filt_sr_q, filt_sr_d;
    logic                  filt_q, filt_d;
    logic                  neg_edge;

    state_t                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic [9:0]            shift_q, shift_d;
    logic                  tick_q, tick_d;
    logic                  busy_q, busy_d;

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [8:0]            mem_q [FIFO_DEPTH];

    logic                  push, pop, full, wr, frame_err;
    logic [8:0]            head;

    // Input conditioning and falling-edge detection on the filtered clock.
    always_comb begin
        ps2d_meta_d = ps2d;
        ps2d_sync_d = ps2d_meta_q;
        filt_sr_d   = {filt_sr_q[FILTER_LEN-2:0], ps2c};
        filt_d      = filt_q;
        if (&filt_sr_q) begin
            filt_d = 1'b1;
        end else if (~|filt_sr_q) begin
            filt_d = 1'b0;
        end
        neg_edge = filt_q & ~filt_d;
    end

    // Frame FSM. shift_q collects bits LSB-first, so after the tenth shift
    // [7:0]=data, [8]=parity, [9]=stop.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        shift_d   = shift_q;
        tick_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (neg_edge && rx_en && !ps2d_sync_q) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 4'd0;
                    tmo_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (tmo_cnt_q == TW'(TIMEOUT_CYC)) begin
                    state_d = ST_IDLE;
                    tick_d  = 1'b1;
                end else if (neg_edge) begin
                    shift_d   = {ps2d_sync_q, shift_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    tmo_cnt_d = '0;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // FIFO bookkeeping. A push into a full FIFO still lands when the same
    // cycle pops, because the pop frees the slot being written.
    always_comb begin
        push       = (state_q == ST_DONE);
        frame_err  = ~(^shift_q[8:0]) | ~shift_q[9];
        pop        = rd_en && (count_q != '0);
        full       = (count_q == CW'(FIFO_DEPTH));
        wr         = push && (!full || pop);
        wr_ptr_d   = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (wr && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!wr && pop) begin
            count_d = count_q - CW'(1);
        end
        // A drop in the same cycle as clr_ovf wins, so no event is lost.
        overflow_d = (push && full && !pop) || (overflow_q && !clr_ovf);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2d_meta_q <= 1'b0;
            ps2d_sync_q <= 1'b0;
            filt_sr_q   <= '0;
            filt_q      <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            tmo_cnt_q   <= '0;
            shift_q     <= '0;
            tick_q      <= 1'b0;
            busy_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            ps2d_meta_q <= ps2d_meta_d;
            ps2d_sync_q <= ps2d_sync_d;
            filt_sr_q   <= filt_sr_d;
            filt_q      <= filt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            shift_q     <= shift_d;
            tick_q      <= tick_d;
            busy_q      <= busy_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage is not reset; the read port is masked while empty instead.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= {frame_err, shift_q[7:0]};
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign rx_valid     = (count_q != '0);
    assign rx_data      = rx_valid ? head[7:0] : 8'h00;
    assign rx_err       = rx_valid & head[8];
    assign fifo_count   = count_q;
    assign overflow     = overflow_q;
    assign timeout_tick = tick_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ps2_rx_buffered.sv
// Bench for ps2_rx_buffered: directed scenarios plus randomized frames,
// checked against a queue-based model of the receive FIFO.
module tb_ps2_rx_buffered;

    localparam int FILTER_LEN  = 4;
    localparam int FIFO_DEPTH  = 4;
    localparam int TIMEOUT_CYC = 1000;
    localparam int HP          = 20;   // clk cycles per PS/2 clock phase

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2d, ps2c, rx_en, rd_en, clr_ovf;
    logic [7:0] rx_data;
    logic       rx_err, rx_valid, overflow, timeout_tick, busy;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    ps2_rx_buffered #(
        .FILTER_LEN (FILTER_LEN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2d        (ps2d),
        .ps2c        (ps2c),
        .rx_en       (rx_en),
        .rd_en       (rd_en),
        .clr_ovf     (clr_ovf),
        .rx_data     (rx_data),
        .rx_err      (rx_err),
        .rx_valid    (rx_valid),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .timeout_tick(timeout_tick),
        .busy        (busy)
    );

    // ---------------- scoreboard / model ----------------
    logic [8:0] exp_q[$];   // {err, data}, head at index 0
    logic       exp_ovf;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entry the receiver should queue for a frame, from the frame rules alone.
    function automatic logic [8:0] model_entry(input logic [7:0] data, input logic parity,
                                               input logic stop);
        logic err;
        err = ((^{data, parity}) != 1'b1) || (stop != 1'b1);
        return {err, data};
    endfunction

    task automatic model_push(input logic [8:0] e);
        if (exp_q.size() >= FIFO_DEPTH) exp_ovf = 1'b1;
        else exp_q.push_back(e);
    endtask

    task automatic check_state(input string tag);
        logic [8:0] h;
        h = (exp_q.size() != 0) ? exp_q[0] : 9'h000;
        check_eq({tag, "_valid"}, rx_valid, exp_q.size() != 0);
        check_eq({tag, "_count"}, fifo_count, exp_q.size());
        check_eq({tag, "_data"}, rx_data, h[7:0]);
        check_eq({tag, "_err"}, rx_err, h[8]);
        check_eq({tag, "_ovf"}, overflow, exp_ovf);
        check_eq({tag, "_busy"}, busy, 1'b0);
    endtask

    // ---------------- driver tasks ----------------
    // Sends the first n_bits of a frame. With pop_at_done, rd_en is pulsed in
    // the DONE cycle of the stop bit: the filtered clock falls FILTER_LEN
    // cycles after the line, DONE follows one cycle later.
    task automatic send_frame(input logic [7:0] data, input logic par_bad, input logic stop,
                              input int n_bits, input bit pop_at_done);
        logic [10:0] f;
        f = {stop, (~^data) ^ par_bad, data, 1'b0};
        for (int i = 0; i < n_bits; i++) begin
            ps2d = f[i];
            wait_cyc(HP / 2);
            ps2c = 1'b0;
            if (pop_at_done && i == 10) begin
                wait_cyc(FILTER_LEN + 1);
                check_eq("busy_in_done", busy, 1'b1);
                rd_en = 1'b1;
                wait_cyc(1);
                rd_en = 1'b0;
                wait_cyc(HP - FILTER_LEN - 2);
            end else begin
                wait_cyc(HP);
            end
            ps2c = 1'b1;
            wait_cyc(HP / 2);
        end
        ps2d = 1'b1;
    endtask

    task automatic send_model(input logic [7:0] data, input logic par_bad, input logic stop);
        logic en_at_start;
        en_at_start = rx_en;
        send_frame(data, par_bad, stop, 11, 1'b0);
        wait_cyc(4);
        if (en_at_start) model_push(model_entry(data, (~^data) ^ par_bad, stop));
    endtask

    task automatic pop_one(input string tag);
        check_state(tag);
        rd_en = 1'b1;
        wait_cyc(1);
        rd_en = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic pulse_clr_ovf();
        clr_ovf = 1'b1;
        wait_cyc(1);
        clr_ovf = 1'b0;
        exp_ovf = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        wait_cyc(3);
        exp_q.delete();
        exp_ovf = 1'b0;
        check_state(tag);
        check_eq({tag, "_tick"}, timeout_tick, 1'b0);
        reset = 1'b0;
        wait_cyc(FILTER_LEN + 6);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        logic [10:0] f;
        ps2d = 1'b1; ps2c = 1'b1; rx_en = 1'b1; rd_en = 1'b0; clr_ovf = 1'b0;
        exp_ovf = 1'b0;
        #1;
        @(negedge clk);
        do_reset("reset");

        // Clean frame, then pop it.
        send_model(8'h1C, 1'b0, 1'b1);
        check_eq("t1_data_const", rx_data, 8'h1C);
        pop_one("t1_head");
        check_state("t1_empty");

        // Parity fault, then stop-bit fault.
        send_model(8'h1C, 1'b1, 1'b1);
        send_model(8'hF0, 1'b0, 1'b0);
        check_eq("t2_count_const", fifo_count, 2);
        pop_one("t2_first");
        pop_one("t2_second");
        check_state("t2_empty");

        // Timeout after start + 4 data bits.
        send_frame(8'h5A, 1'b0, 1'b1, 4, 1'b0);
        f = {1'b1, ~^8'h5A, 8'h5A, 1'b0};
        ps2d = f[4];
        wait_cyc(HP / 2);
        ps2c = 1'b0;
        k = 0;
        while (k < 3000) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (k == HP) ps2c = 1'b1;
            if (timeout_tick) break;
        end
        // Edge seen FILTER_LEN cycles after the line falls, counter is 0 the
        // cycle after that edge, hits TIMEOUT_CYC then ticks one cycle later.
        check_eq("tmo_latency", k, FILTER_LEN + TIMEOUT_CYC + 2);
        check_eq("tmo_busy", busy, 1'b0);
        wait_cyc(1);
        check_eq("tmo_tick_once", timeout_tick, 1'b0);
        ps2d = 1'b1;
        wait_cyc(HP);
        check_state("tmo_after");
        send_model(8'hF0, 1'b0, 1'b1);
        pop_one("tmo_next_frame");

        // Overflow with five frames into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) send_model(8'(i), 1'b0, 1'b1);
        check_eq("ovf_flag_const", overflow, 1'b1);
        for (int i = 0; i < 4; i++) pop_one("ovf_pop");
        check_state("ovf_drained");
        pulse_clr_ovf();
        check_state("ovf_cleared");

        // Full FIFO with a pop in the DONE cycle of a new frame.
        for (int i = 0; i < 4; i++) send_model(8'h11 + 8'(i), 1'b0, 1'b1);
        send_frame(8'h99, 1'b0, 1'b1, 11, 1'b1);
        wait_cyc(4);
        void'(exp_q.pop_front());
        model_push(model_entry(8'h99, ~^8'h99, 1'b1));
        check_state("full_pushpop");
        for (int i = 0; i < 4; i++) pop_one("full_drain");
        check_state("full_empty");

        // Short glitch on ps2c while idle.
        ps2d = 1'b0;
        wait_cyc(HP / 2);
        ps2c = 1'b0;
        wait_cyc(FILTER_LEN - 1);
        ps2c = 1'b1;
        wait_cyc(FILTER_LEN + 4);
        ps2d = 1'b1;
        check_state("glitch");

        // Start edge while rx_en is low.
        rx_en = 1'b0;
        send_model(8'h3C, 1'b0, 1'b1);
        rx_en = 1'b1;
        check_state("rx_en_off");

        // Reset in the middle of a frame with a byte queued.
        send_model(8'h42, 1'b0, 1'b1);
        send_frame(8'h77, 1'b0, 1'b1, 4, 1'b0);
        check_eq("mid_busy", busy, 1'b1);
        do_reset("mid_reset");
        send_model(8'hA5, 1'b0, 1'b1);
        pop_one("post_reset");

        // Randomized frames, pops, enables and overflow clears.
        for (int it = 0; it < 40; it++) begin
            rx_en = ($urandom_range(0, 7) != 0);
            send_model(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0));
            rx_en = 1'b1;
            check_state("rnd_frame");
            for (int p = $urandom_range(0, 2); p > 0; p--) pop_one("rnd_pop");
            if ($urandom_range(0, 5) == 0) pulse_clr_ovf();
        end
        while (exp_q.size() != 0) pop_one("rnd_drain");
        check_state("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_rx_buffered.md
# ps2_rx_buffered

Parametrised PS/2 device-to-host receiver that deserialises 11-bit PS/2 frames, checks odd parity, stop bit and inter-edge timeout, and queues received bytes with per-byte error flags in an internal FIFO. It sits between the PS/2 pins and the keyboard/scan-code control logic. It replaces the single-byte receiver: the consumer drains bytes at its own pace through a show-ahead read port instead of acknowledging each byte individually.

## Interface
- FILTER_LEN, 8: ps2c glitch-filter length in clk cycles, ≥2.
- FIFO_DEPTH, 16: entries; power of two, ≥2.
- TIMEOUT_CYC, 50000: max clk cycles between falling ps2c edges inside a frame.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ps2d  in  1  PS/2 data line (asynchronous).
- ps2c  in  1  PS/2 clock line (asynchronous).
- rx_en  in  1  allows a new frame to start; a frame in progress always completes.
- rd_en  in  1  pop the head entry; ignored when empty.
- clr_ovf  in  1  clears overflow.
- rx_data  out  8  head entry data byte (show-ahead).
- rx_err  out  1  head entry error flag (parity or stop-bit fault).
- rx_valid  out  1  FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held.
- overflow  out  1  sticky: a completed frame was dropped because the FIFO was full.
- timeout_tick  out  1  one-cycle pulse when a frame is aborted by timeout.
- busy  out  1  FSM not in IDLE.

## Operation
- ps2d passes through a 2-flop synchroniser; ps2c shifts into a FILTER_LEN-bit register; the filtered value becomes 1 when all bits are 1 and 0 when all bits are 0, otherwise it holds.
- neg_edge is asserted when the registered filtered value is 1 and its next value is 0. Data is sampled on that same cycle from the synchronised ps2d.
- FSM states:
  - IDLE: neg_edge & rx_en & ps2d==0 → SHIFT, with bit counter=0 and timeout counter cleared. A start edge with ps2d==1 is ignored.
  - SHIFT: each neg_edge shifts ps2d in LSB-first and increments the bit counter. Bits 0–7 are data, bit 8 is parity, bit 9 is stop. The edge that samples bit 9 → DONE.
  - DONE: one cycle. err = (^{data,parity} != 1) | (stop != 1). Push {err,data}, then → IDLE.
- Timeout: in SHIFT, the counter increments every cycle and clears on each neg_edge. On reaching TIMEOUT_CYC: → IDLE, one-cycle timeout_tick, nothing pushed.
- FIFO: circular buffer with wrapping read/write pointers.
  - Push when full without a simultaneous pop: entry dropped, overflow set.
  - Push and pop in the same cycle: both take effect, count unchanged, including when full.
  - Pop when empty: no effect.
- overflow stays set until a clr_ovf cycle. If an overflow event and clr_ovf occur in the same cycle, overflow stays 1.
- rx_en deassertion mid-frame does not abort the frame.
- Reset (any time, including mid-frame) clears the FSM, counters, pointers, filter, synchroniser and all flags.

## Timing
- Reset values: rx_data=0, rx_err=0, rx_valid=0, fifo_count=0, overflow=0, timeout_tick=0, busy=0; filtered ps2c=0.
- Filter delay: filtered ps2c falls FILTER_LEN+1 cycles after a clean ps2c fall.
- Stop-bit neg_edge in cycle N: DONE in N+1, then rx_valid and fifo_count update in N+2.
- rd_en in cycle N with rx_valid=1: the new head appears on rx_data/rx_err in N+1; fifo_count decrements in N+1.
- timeout_tick is asserted in the cycle after the counter reaches TIMEOUT_CYC; busy is 0 in that same cycle.
- busy is 1 from the cycle after the start edge through the DONE cycle inclusive.

## Test plan
- Frame 0x1C, parity 0, stop 1, no pop → rx_valid=1, rx_data=0x1C, rx_err=0, fifo_count=1; rd_en for one cycle → rx_valid=0.
- Frame 0x1C with parity 1, then 0xF0 (parity 1) with stop bit 0 → two entries, both with rx_err=1, data 0x1C then 0xF0.
- TIMEOUT_CYC=1000; stop ps2c toggling after 4 data bits → timeout_tick pulse at 1000 cycles after the last edge, fifo_count=0. Next good frame 0xF0 is received with rx_err=0.
- FIFO_DEPTH=4; five frames 0x01..0x05 with no pops → fifo_count=4, overflow=1, pops yield 0x01..0x04. clr_ovf → overflow=0.
- Full FIFO; rd_en asserted in the DONE cycle of a new frame → no overflow, fifo_count stays 4, newest byte is last out.
- ps2c low pulse of FILTER_LEN-1 cycles while idle → no start, busy=0. rx_en=0 at start edge → ignored. Reset asserted mid-frame → all outputs 0, then a following good frame is received correctly.
